// File: rtl/ivl_uvm_ovl_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ivl_uvm_ovl_clk_pkg
// Purpose  : Shared types and widths for the clock checker.
// Revision : 1.0 - initial release
// ============================================================================
package ivl_uvm_ovl_clk_pkg;

    localparam int C_CNT_W_DEFAULT = 16;
    localparam int C_SAT_CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } clk_chk_state_e;

endpackage
`default_nettype wire

// File: rtl/ivl_uvm_ovl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : ivl_uvm_ovl_sync_edge
// Purpose  : 2-flop synchronizer with rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module ivl_uvm_ovl_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_dly;

endmodule
`default_nettype wire

// File: rtl/ivl_uvm_ovl_clk_checker.sv
`default_nettype none
// ============================================================================
// Module   : ivl_uvm_ovl_clk_checker
// Purpose  : Measures period/high time of a sampled clock, checks the period
//            against a tolerance window, flags a stuck clock, counts results.
// Revision : 1.0 - initial release
// ============================================================================
module ivl_uvm_ovl_clk_checker
    import ivl_uvm_ovl_clk_pkg::*;
#(
    parameter int CNT_W      = C_CNT_W_DEFAULT,
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mon_in,
    output logic [CNT_W-1:0]       period,
    output logic [CNT_W-1:0]       high_time,
    output logic                   meas_valid,
    output logic                   meas_ok,
    output logic                   meas_err,
    output logic                   stuck,
    output logic [C_SAT_CNT_W-1:0] ok_cnt,
    output logic [C_SAT_CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0]       C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]       C_ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]         C_LO      = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0]         C_HI      = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [C_SAT_CNT_W-1:0] C_SAT_MAX = '1;
    localparam logic [C_SAT_CNT_W-1:0] C_SAT_ONE = C_SAT_CNT_W'(1);

    logic                   w_level;
    logic                   w_rise;
    logic                   w_cnt_sat;
    logic                   w_hi_sat;
    logic [CNT_W:0]         w_cnt_ext;
    logic                   w_in_tol;

    clk_chk_state_e         r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;
    logic                   r_valid;
    logic                   r_ok;
    logic                   r_err;
    logic                   r_stuck;
    logic [C_SAT_CNT_W-1:0] r_ok_cnt;
    logic [C_SAT_CNT_W-1:0] r_err_cnt;

    ivl_uvm_ovl_sync_edge u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (mon_in),
        .level (w_level),
        .rise  (w_rise)
    );

    assign w_cnt_sat = (r_cnt == C_TIMEOUT);
    assign w_hi_sat  = (r_hi == C_TIMEOUT);
    // One extra bit keeps the window compare from wrapping near the top of the range.
    assign w_cnt_ext = {1'b0, r_cnt};
    assign w_in_tol  = (w_cnt_ext >= C_LO) && (w_cnt_ext <= C_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_ok        <= 1'b0;
            r_err       <= 1'b0;
            r_stuck     <= 1'b0;
            r_ok_cnt    <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;

            if (r_ok && (r_ok_cnt != C_SAT_MAX)) begin
                r_ok_cnt <= r_ok_cnt + C_SAT_ONE;
            end
            if (r_err && (r_err_cnt != C_SAT_MAX)) begin
                r_err_cnt <= r_err_cnt + C_SAT_ONE;
            end

            if (!en) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_hi    <= '0;
                r_stuck <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_state <= ST_MEAS;
                            r_cnt   <= C_ONE;
                            r_hi    <= C_ONE;
                            r_stuck <= 1'b0;
                        end else if (w_cnt_sat) begin
                            r_stuck <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                        end
                    end
                    ST_MEAS: begin
                        // An edge coinciding with the timeout is still a valid measurement.
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hi;
                            r_valid     <= 1'b1;
                            r_ok        <= w_in_tol;
                            r_err       <= ~w_in_tol;
                            r_cnt       <= C_ONE;
                            r_hi        <= C_ONE;
                        end else if (w_cnt_sat) begin
                            r_stuck <= 1'b1;
                            r_state <= ST_ARM;
                            r_cnt   <= '0;
                            r_hi    <= '0;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                            if (w_level && !w_hi_sat) begin
                                r_hi <= r_hi + C_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_valid;
    assign meas_ok    = r_ok;
    assign meas_err   = r_err;
    assign stuck      = r_stuck;
    assign ok_cnt     = r_ok_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ivl_uvm_ovl_clk_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ivl_uvm_ovl_clk_checker
// Purpose  : Directed bench with a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ivl_uvm_ovl_clk_checker;

    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 10;
    localparam int TOL        = 1;
    localparam int TIMEOUT    = 64;
    localparam int HMAX       = 8192;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mon_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             meas_ok;
    logic             meas_err;
    logic             stuck;
    logic [7:0]       ok_cnt;
    logic [7:0]       err_cnt;

    int checks = 0;
    int errors = 0;

    ivl_uvm_ovl_clk_checker #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mon_in     (mon_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .meas_ok    (meas_ok),
        .meas_err   (meas_err),
        .stuck      (stuck),
        .ok_cnt     (ok_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle input history; the model derives the synchronized level from it.
    bit mon_h [HMAX];
    bit rst_h [HMAX];
    int n = -1;

    int phase     = 0;   // 0 idle, 1 waiting for first edge, 2 measuring
    int ref_c     = 0;   // cycle of last edge (measuring) or of count restart (waiting)
    int e_period  = 0;
    int e_high    = 0;
    int e_ok_cnt  = 0;
    int e_err_cnt = 0;
    bit e_valid   = 1'b0;
    bit e_ok      = 1'b0;
    bit e_err     = 1'b0;
    bit e_stuck   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    function automatic bit lv(input int k);
        if (k < 2 || k >= HMAX) return 1'b0;
        if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
        return mon_h[k-2];
    endfunction

    always @(negedge clk) begin : p_model
        bit nv;
        bit nok;
        bit rs;
        int s;
        n++;
        if (n < HMAX) begin
            mon_h[n] = mon_in;
            rst_h[n] = rst;
        end
        if (n >= 1) begin
            chk("period",     32'(period),    e_period);
            chk("high_time",  32'(high_time), e_high);
            chk("meas_valid", 32'(meas_valid), int'(e_valid));
            chk("meas_ok",    32'(meas_ok),   int'(e_ok));
            chk("meas_err",   32'(meas_err),  int'(e_err));
            chk("stuck",      32'(stuck),     int'(e_stuck));
            chk("ok_cnt",     32'(ok_cnt),    e_ok_cnt);
            chk("err_cnt",    32'(err_cnt),   e_err_cnt);
        end

        if (rst) begin
            phase = 0; e_period = 0; e_high = 0; e_ok_cnt = 0; e_err_cnt = 0;
            e_valid = 1'b0; e_ok = 1'b0; e_err = 1'b0; e_stuck = 1'b0;
        end else begin
            nv = 1'b0;
            nok = 1'b0;
            rs = lv(n) && !lv(n-1);
            if (e_ok && e_ok_cnt < 255) e_ok_cnt++;
            if (e_err && e_err_cnt < 255) e_err_cnt++;
            if (!en) begin
                phase = 0;
                e_stuck = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        phase = 1;
                        ref_c = n + 1;
                    end
                    1: begin
                        if (rs) begin
                            phase = 2;
                            ref_c = n;
                            e_stuck = 1'b0;
                        end else if (n - ref_c == TIMEOUT) begin
                            e_stuck = 1'b1;
                            ref_c = n + 1;
                        end
                    end
                    default: begin
                        if (rs) begin
                            s = 0;
                            for (int k = ref_c; k < n; k++) s += int'(lv(k));
                            e_period = n - ref_c;
                            e_high = s;
                            nv = 1'b1;
                            nok = (e_period >= EXP_PERIOD - TOL) && (e_period <= EXP_PERIOD + TOL);
                            ref_c = n;
                        end else if (n - ref_c == TIMEOUT) begin
                            e_stuck = 1'b1;
                            phase = 1;
                            ref_c = n + 1;
                        end
                    end
                endcase
            end
            e_valid = nv;
            e_ok = nv && nok;
            e_err = nv && !nok;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic per(input int h, input int l);
        mon_in = 1'b1;
        repeat (h) tick();
        mon_in = 1'b0;
        repeat (l) tick();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        mon_in = 1'b0;
        repeat (3) tick();
        chk("lit_reset_period", 32'(period), 0);
        chk("lit_reset_ok_cnt", 32'(ok_cnt), 0);
        chk("lit_reset_stuck",  32'(stuck),  0);
        rst = 1'b0;
        en = 1'b1;

        // Nominal 5/5 clock: first edge only arms.
        repeat (20) per(5, 5);
        chk("lit_nom_ok_cnt",    32'(ok_cnt),    19);
        chk("lit_nom_period",    32'(period),    10);
        chk("lit_nom_high_time", 32'(high_time), 5);

        // Periods 11 (in window) then 12 (out), then a long low stretch.
        per(6, 5);
        per(6, 6);
        per(5, 100);
        chk("lit_tol_err_cnt",   32'(err_cnt),   1);
        chk("lit_tol_ok_cnt",    32'(ok_cnt),    21);
        chk("lit_tol_period",    32'(period),    12);
        chk("lit_tol_high_time", 32'(high_time), 6);
        chk("lit_stuck_set",     32'(stuck),     1);

        // First edge clears stuck without a measurement.
        per(5, 5);
        chk("lit_stuck_clear",   32'(stuck),  0);
        chk("lit_stuck_no_meas", 32'(ok_cnt), 21);
        per(6, 5);

        // Enable drop mid-period.
        mon_in = 1'b1;
        repeat (5) tick();
        mon_in = 1'b0;
        repeat (2) tick();
        en = 1'b0;
        repeat (3) tick();
        chk("lit_en_period_hold", 32'(period), 11);
        chk("lit_en_ok_cnt",      32'(ok_cnt), 23);
        en = 1'b1;
        per(5, 5);
        chk("lit_rearm_period", 32'(period), 11);
        chk("lit_rearm_ok_cnt", 32'(ok_cnt), 23);
        per(5, 5);
        chk("lit_after_rearm_ok_cnt", 32'(ok_cnt), 24);

        // Reset 4 cycles into a period.
        mon_in = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("lit_rst_ok_cnt",    32'(ok_cnt),    0);
        chk("lit_rst_period",    32'(period),    0);
        chk("lit_rst_high_time", 32'(high_time), 0);
        chk("lit_rst_valid",     32'(meas_valid), 0);
        rst = 1'b0;
        tick();
        mon_in = 1'b0;
        repeat (5) tick();

        // Window boundaries, then saturation of the error count.
        per(4, 5);
        per(4, 4);
        per(5, 6);
        repeat (300) per(3, 4);
        chk("lit_err_saturated", 32'(err_cnt), 255);
        mon_in = 1'b0;
        repeat (10) tick();
        en = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ivl_uvm_ovl_clk_checker.md
# ivl_uvm_ovl_clk_checker

Synthesizable clock monitor: the receiving end of the `ivl_uvm_ovl_clk_gen` clock generators. It samples a generated clock (`mon_in`) in a faster system clock domain. It measures period and high time of every cycle in system-clock cycles and compares the period against an expected value within a tolerance. It flags a stuck clock and keeps saturating pass/fail counts. It lives in the verification IP alongside the generator and replaces simulation-only period assertions with a checker that also runs in emulation.

## Interface
Parameters:
- `CNT_W`, 16: width of all period/high-time counters.
- `EXP_PERIOD`, 10: expected period of `mon_in`, in `clk` cycles. Must be greater than `TOL`.
- `TOL`, 0: allowed absolute deviation from `EXP_PERIOD`, in `clk` cycles.
- `TIMEOUT`, 64: `clk` cycles without a rising edge before stuck is declared. Must be less than 2^CNT_W.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system sampling clock; all logic is on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  monitor enable.
- `mon_in`  in  1  monitored clock, asynchronous to `clk`.
- `period`  out  CNT_W  last measured period.
- `high_time`  out  CNT_W  last measured high time.
- `meas_valid`  out  1  one-cycle pulse; a new `period`/`high_time` is available.
- `meas_ok`  out  1  pulse with `meas_valid`; the period is within tolerance.
- `meas_err`  out  1  pulse with `meas_valid`; the period is out of tolerance.
- `stuck`  out  1  level; no rising edge seen for `TIMEOUT` cycles.
- `ok_cnt`  out  8  saturating count of `meas_ok` pulses.
- `err_cnt`  out  8  saturating count of `meas_err` pulses.

## Operation
- `mon_in` passes through a 2-flop synchronizer.
- A rising edge (`rise`) is detected when the second synchronizer flop is 1 and the delayed copy is 0.
- FSM states: IDLE, ARM, MEAS.
  - IDLE: counters held at 0. Moves to ARM when `en`=1.
  - ARM: waits for the first `rise`. On `rise`, goes to MEAS and loads `cnt`=1 and `hi`=1. No measurement is emitted.
  - MEAS: `cnt` increments every cycle. `hi` increments on each cycle where the synchronized level is 1.
  - On `rise` in MEAS: capture `period`=`cnt` and `high_time`=`hi`, pulse `meas_valid`, reload `cnt`=1 and `hi`=1, stay in MEAS.
- Both `cnt` and `hi` saturate at `TIMEOUT`.
- Check: pass if `EXP_PERIOD-TOL <= period <= EXP_PERIOD+TOL`, else fail. Compute in CNT_W+1 bits so the comparison cannot wrap.
- Stuck detection:
  - In ARM or MEAS, when `cnt` reaches `TIMEOUT`: set `stuck`=1 and go to ARM.
  - `stuck` clears on the next `rise`; that edge re-arms and produces no measurement.
  - In ARM, `cnt` counts cycles since entering ARM.
- `en`=0 in any state: go to IDLE next cycle, clear `stuck`, emit no pulse. `period`, `high_time` and the counts hold.
- `ok_cnt` and `err_cnt` saturate at 255 and clear only on `rst`.
- `rise` in the same cycle that `cnt` reaches `TIMEOUT`: the edge wins. Capture it as a normal measurement; `stuck` is not set.
- `rise` in the same cycle as `en` falling: `en` wins; no pulse.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchronizer flops 0.
- `mon_in` rising to `rise` asserted: 2–3 `clk` cycles, due to synchronizer uncertainty.
- `rise` to `meas_valid`/`meas_ok`/`meas_err`: 1 cycle, registered. `period` and `high_time` update in the same cycle as the pulse.
- `ok_cnt`/`err_cnt` update 1 cycle after the pulse.
- `stuck` asserts in the cycle after `cnt` reaches `TIMEOUT`.
- `rst` asserted mid-measurement: all state and outputs return to reset values on the next edge, counts included. Pulses in flight are dropped.

## Structure
- Package `ivl_uvm_ovl_clk_pkg` holds:
  - the `clk_chk_state_e` enum (IDLE, ARM, MEAS);
  - the default `CNT_W`;
  - the counter width of 8.
- Sub-module `ivl_uvm_ovl_sync_edge`: 2-flop synchronizer plus rising-edge detector. Outputs are `level` and `rise`; reset is synchronous.
- The top level holds the FSM, the counters, the compare logic and the saturating counts.

## Test plan
- `EXP_PERIOD`=10, `TOL`=0, `mon_in` 5 cycles high / 5 low, `en`=1 → from the second edge on, every `meas_valid` has `period`=10, `high_time`=5 and `meas_ok`=1. After 20 periods, `ok_cnt`=19.
- `TOL`=1, periods 11 then 12 → first gives `meas_ok`; second gives `meas_err` with `period`=12 and `err_cnt`=1.
- `mon_in` held 0 for 100 cycles, `TIMEOUT`=64 → `stuck`=1 about 64 cycles after the last edge. The first new edge clears `stuck` with no pulse; the second edge produces a measurement.
- `en` dropped for 3 cycles mid-period → no pulse; the FSM re-arms. The first edge after re-enable produces no measurement; `period` holds its old value throughout.
- `rst` pulsed 4 cycles into a period while `ok_cnt`=7 → all outputs 0 next cycle, FSM in IDLE.
- 300 out-of-tolerance periods → `err_cnt` saturates at 255 and holds; `meas_err` keeps pulsing.
